combination_block_mc: RTL and testbench

//  GCN aggregation stage: ADJ_FM_WM[dst] += FM_WM[src] over a runtime-length COO edge list, one edge per cycle.

---
 rtl/combination_block_mc.sv | 269 ++++++++++++++++++++++++++
 tb/tb_combination_block_mc.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combination_block_mc.sv
// combination_block_mc
//   GCN aggregation stage: ADJ_FM_WM[dst] += FM_WM[src] over a COO edge list,
//   one edge per clock, with an optional self-loop pass afterwards.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   done_trans        FM_WM ready; a 0->1 transition seen in IDLE starts a run
//   num_edges         edge count for the run, clamped to COO_NUM_OF_COLS
//   coo_in[0:1]       source / destination node id of edge coo_address
//   fm_wm_row_data    FM_WM[read_fm_wm_row], returned combinationally
//   read_row          read-out row select
//   coo_address       edge index being fetched (0 outside EDGE)
//   read_fm_wm_row    FM_WM row being fetched (0 outside EDGE/SELF)
//   done_comb         aggregation complete (held in DONE)
//   adj_fm_wm_row     ADJ_FM_WM[read_row], one cycle after read_row
//   bad_edge          sticky: at least one edge skipped this run
//   overflow          sticky: at least one element sum carried out
module combination_block_mc #(
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_COLS     = 3,
  parameter int DOT_PROD_WIDTH  = 16,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int NODE_BW         = $clog2(FEATURE_ROWS + 1),
  parameter int FEATURE_WIDTH   = $clog2(FEATURE_ROWS),
  parameter int ONE_INDEXED     = 1,
  parameter int SELF_LOOP       = 0,
  parameter int SATURATE        = 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           done_trans,
  input  logic [COO_BW:0]                                num_edges,
  input  logic [NODE_BW-1:0]                             coo_in [0:1],
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]     fm_wm_row_data,
  input  logic [FEATURE_WIDTH-1:0]                       read_row,
  output logic [COO_BW-1:0]                              coo_address,
  output logic [FEATURE_WIDTH-1:0]                       read_fm_wm_row,
  output logic                                           done_comb,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]     adj_fm_wm_row,
  output logic                                           bad_edge,
  output logic                                           overflow
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_EDGE  = 3'd2,
    ST_SELF  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

  // Counter walks either the edge list or the node rows.
  localparam int CNT_BW = ((COO_BW + 1) > (FEATURE_WIDTH + 1)) ? (COO_BW + 1) : (FEATURE_WIDTH + 1);
  localparam logic [NODE_BW:0] ID_LO     = (NODE_BW + 1)'(ONE_INDEXED);
  localparam logic [NODE_BW:0] ID_HI     = (NODE_BW + 1)'(FEATURE_ROWS + ONE_INDEXED);
  localparam logic [COO_BW:0]  MAX_EDGES = (COO_BW + 1)'(COO_NUM_OF_COLS);
  localparam logic [DOT_PROD_WIDTH-1:0] ALL_ONES = {DOT_PROD_WIDTH{1'b1}};
  localparam row_t ROW_ZERO = {(WEIGHT_COLS * DOT_PROD_WIDTH){1'b0}};

  // Element add: returns {carry, result}; result is clamped or wrapped.
  function automatic logic [DOT_PROD_WIDTH:0] add_elem(input logic [DOT_PROD_WIDTH-1:0] a,
                                                       input logic [DOT_PROD_WIDTH-1:0] b);
    logic [DOT_PROD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DOT_PROD_WIDTH] && (SATURATE != 0)) begin
      add_elem = {1'b1, ALL_ONES};
    end else begin
      add_elem = s;
    end
  endfunction

  state_t                    state_r;
  logic                      trans_d_r;
  logic                      armed_r;
  logic [COO_BW:0]           num_edges_r;
  logic [CNT_BW-1:0]         cnt_r;
  row_t                      adj_r [FEATURE_ROWS];
  logic                      bad_edge_r;
  logic                      overflow_r;
  logic                      done_comb_r;
  row_t                      adj_row_r;

  logic                      start_s;
  logic [COO_BW:0]           ne_clamp_s;
  logic [NODE_BW-1:0]        src_idx_s;
  logic [NODE_BW-1:0]        dst_idx_s;
  logic                      src_ok_s;
  logic                      dst_ok_s;
  logic                      wr_en_s;
  logic [FEATURE_WIDTH-1:0]  wr_row_s;
  logic [FEATURE_WIDTH-1:0]  fetch_row_s;
  logic [COO_BW-1:0]         addr_s;
  row_t                      acc_row_s;
  row_t                      sum_row_s;
  row_t                      rd_row_s;
  logic                      carry_s;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH:0] add_res_s;

  // armed_r blocks a start on a done_trans level that is already high when reset lifts.
  assign start_s    = armed_r & done_trans & ~trans_d_r;
  assign ne_clamp_s = (num_edges > MAX_EDGES) ? MAX_EDGES : num_edges;

  // Node id range check and index adjust for the current edge.
  always_comb begin
    src_idx_s = coo_in[0] - NODE_BW'(ONE_INDEXED);
    dst_idx_s = coo_in[1] - NODE_BW'(ONE_INDEXED);
    src_ok_s  = ({1'b0, coo_in[0]} >= ID_LO) && ({1'b0, coo_in[0]} < ID_HI);
    dst_ok_s  = ({1'b0, coo_in[1]} >= ID_LO) && ({1'b0, coo_in[1]} < ID_HI);
  end

  // Fetch addresses and accumulator write target per state.
  always_comb begin
    addr_s      = {COO_BW{1'b0}};
    fetch_row_s = {FEATURE_WIDTH{1'b0}};
    wr_en_s     = 1'b0;
    wr_row_s    = {FEATURE_WIDTH{1'b0}};
    if (state_r == ST_EDGE) begin
      addr_s      = cnt_r[COO_BW-1:0];
      fetch_row_s = src_ok_s ? src_idx_s[FEATURE_WIDTH-1:0] : {FEATURE_WIDTH{1'b0}};
      wr_en_s     = src_ok_s & dst_ok_s;
      wr_row_s    = dst_idx_s[FEATURE_WIDTH-1:0];
    end else if (state_r == ST_SELF) begin
      fetch_row_s = cnt_r[FEATURE_WIDTH-1:0];
      wr_en_s     = 1'b1;
      wr_row_s    = cnt_r[FEATURE_WIDTH-1:0];
    end else begin
      wr_en_s     = 1'b0;
    end
  end

  // Read-modify-write operand comes straight from the register array, so
  // back-to-back writes to one row always see the previous cycle's result.
  always_comb begin
    acc_row_s = ROW_ZERO;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      acc_row_s = (wr_row_s == FEATURE_WIDTH'(r)) ? adj_r[r] : acc_row_s;
    end
  end

  // Per-element adders.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      add_res_s[c] = add_elem(acc_row_s[c], fm_wm_row_data[c]);
    end
  end

  // Split adder results into the new row and a combined carry flag.
  always_comb begin
    sum_row_s = ROW_ZERO;
    carry_s   = 1'b0;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      sum_row_s[c] = add_res_s[c][DOT_PROD_WIDTH-1:0];
      carry_s      = carry_s | add_res_s[c][DOT_PROD_WIDTH];
    end
  end

  // Read-port mux; rows beyond FEATURE_ROWS read as zero.
  always_comb begin
    rd_row_s = ROW_ZERO;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      rd_row_s = (read_row == FEATURE_WIDTH'(r)) ? adj_r[r] : rd_row_s;
    end
  end

  // Control FSM with its registered flags and done output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      trans_d_r   <= 1'b0;
      armed_r     <= 1'b0;
      num_edges_r <= {(COO_BW + 1){1'b0}};
      cnt_r       <= {CNT_BW{1'b0}};
      bad_edge_r  <= 1'b0;
      overflow_r  <= 1'b0;
      done_comb_r <= 1'b0;
    end else begin
      trans_d_r   <= done_trans;
      armed_r     <= 1'b1;
      done_comb_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            num_edges_r <= ne_clamp_s;
            state_r     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_r      <= {CNT_BW{1'b0}};
          bad_edge_r <= 1'b0;
          overflow_r <= 1'b0;
          if (num_edges_r == {(COO_BW + 1){1'b0}}) begin
            state_r <= (SELF_LOOP != 0) ? ST_SELF : ST_DONE;
          end else begin
            state_r <= ST_EDGE;
          end
        end
        ST_EDGE: begin
          if (wr_en_s) begin
            overflow_r <= overflow_r | carry_s;
          end else begin
            bad_edge_r <= 1'b1;
          end
          if (cnt_r == (CNT_BW'(num_edges_r) - CNT_BW'(1'b1))) begin
            cnt_r   <= {CNT_BW{1'b0}};
            state_r <= (SELF_LOOP != 0) ? ST_SELF : ST_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_BW'(1'b1);
          end
        end
        ST_SELF: begin
          overflow_r <= overflow_r | carry_s;
          if (cnt_r == CNT_BW'(FEATURE_ROWS - 1)) begin
            cnt_r   <= {CNT_BW{1'b0}};
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_BW'(1'b1);
          end
        end
        ST_DONE: begin
          if (!done_trans) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Accumulator array: cleared in CLEAR, written one row per cycle otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        adj_r[r] <= ROW_ZERO;
      end
    end else if (state_r == ST_CLEAR) begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        adj_r[r] <= ROW_ZERO;
      end
    end else if (wr_en_s) begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        if (wr_row_s == FEATURE_WIDTH'(r)) begin
          adj_r[r] <= sum_row_s;
        end
      end
    end
  end

  // Registered read port, active in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adj_row_r <= ROW_ZERO;
    end else begin
      adj_row_r <= rd_row_s;
    end
  end

  assign coo_address    = addr_s;
  assign read_fm_wm_row = fetch_row_s;
  assign done_comb      = done_comb_r;
  assign adj_fm_wm_row  = adj_row_r;
  assign bad_edge       = bad_edge_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_combination_block_mc.sv
// tb_combination_block_mc
//   Three instances share stimulus: u[0] default, u[1] SELF_LOOP=1,
//   u[2] SATURATE=0. Stimulus pushes expectations into sb_q; the monitor
//   checks read-port rows when due and done_comb rises/falls as they happen.
module tb_combination_block_mc;

  typedef logic [47:0] row_t;

  typedef struct {
    int    kind;   // 0 row read, 1 done latency, 2 done pulse width
    int    dut;
    int    tag;    // row: negedge cycle to check; done: start posedge
    int    lat;
    row_t  row;
    logic  bad;
    logic  ovf;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       done_trans;
  logic [3:0] num_edges;
  logic [2:0] read_row;

  logic [2:0][2:0]  addr_v;
  logic [2:0][2:0]  fetch_v;
  logic [2:0]       done_v;
  logic [2:0][47:0] adj_v;
  logic [2:0]       bad_v;
  logic [2:0]       ovf_v;

  row_t       fm_mem  [8];
  logic [2:0] src_mem [8];
  logic [2:0] dst_mem [8];

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [2:0] coo_g [0:1];
    row_t       fm_g;
    assign coo_g[0] = src_mem[addr_v[g]];
    assign coo_g[1] = dst_mem[addr_v[g]];
    assign fm_g     = fm_mem[fetch_v[g]];
    combination_block_mc #(
      .SELF_LOOP ((g == 1) ? 1 : 0),
      .SATURATE  ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .done_trans     (done_trans),
      .num_edges      (num_edges),
      .coo_in         (coo_g),
      .fm_wm_row_data (fm_g),
      .read_row       (read_row),
      .coo_address    (addr_v[g]),
      .read_fm_wm_row (fetch_v[g]),
      .done_comb      (done_v[g]),
      .adj_fm_wm_row  (adj_v[g]),
      .bad_edge       (bad_v[g]),
      .overflow       (ovf_v[g])
    );
  end

  function automatic row_t row3(input int a, input int b, input int c);
    logic [15:0] a16, b16, c16;
    a16 = a[15:0];
    b16 = b[15:0];
    c16 = c[15:0];
    return {c16, b16, a16};
  endfunction

  // ---------------- monitor ----------------
  logic [2:0] done_prev = 3'b000;
  int         rise_cyc [3];

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].kind == 0 && sb_q[i].tag == cyc) begin
        int d;
        d = sb_q[i].dut;
        checks++;
        if (adj_v[d] !== sb_q[i].row || bad_v[d] !== sb_q[i].bad || ovf_v[d] !== sb_q[i].ovf) begin
          errors++;
          $display("FAIL %s u%0d: got row=%h bad=%b ovf=%b, want row=%h bad=%b ovf=%b",
                   sb_q[i].name, d, adj_v[d], bad_v[d], ovf_v[d], sb_q[i].row, sb_q[i].bad, sb_q[i].ovf);
        end
        sb_q.delete(i);
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (done_v[d] && !done_prev[d]) begin
        int hit;
        hit = -1;
        rise_cyc[d] = cyc;
        for (int i = 0; i < sb_q.size(); i++) begin
          if (hit < 0 && sb_q[i].kind == 1 && sb_q[i].dut == d) hit = i;
        end
        checks++;
        if (hit < 0) begin
          errors++;
          $display("FAIL done_unexpected u%0d: done_comb rose at cycle %0d, want no rise", d, cyc);
        end else begin
          if (cyc - sb_q[hit].tag != sb_q[hit].lat) begin
            errors++;
            $display("FAIL %s u%0d: got %0d cycles, want %0d", sb_q[hit].name, d,
                     cyc - sb_q[hit].tag, sb_q[hit].lat);
          end
          sb_q.delete(hit);
        end
      end
      if (!done_v[d] && done_prev[d]) begin
        int hit;
        hit = -1;
        for (int i = 0; i < sb_q.size(); i++) begin
          if (hit < 0 && sb_q[i].kind == 2 && sb_q[i].dut == d) hit = i;
        end
        if (hit >= 0) begin
          checks++;
          if (cyc - rise_cyc[d] != sb_q[hit].lat) begin
            errors++;
            $display("FAIL %s u%0d: got width %0d, want %0d", sb_q[hit].name, d,
                     cyc - rise_cyc[d], sb_q[hit].lat);
          end
          sb_q.delete(hit);
        end
      end
    end
    done_prev = done_v;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic expect_row(input string nm, input int d, input int r, input row_t e,
                            input logic b, input logic o);
    exp_t x;
    @(negedge clk);
    read_row = r[2:0];
    x.kind = 0; x.dut = d; x.tag = cyc + 1; x.lat = 0;
    x.row = e; x.bad = b; x.ovf = o; x.name = nm;
    sb_q.push_back(x);
  endtask

  task automatic run(input int ne, input bit drop);
    exp_t x;
    int   n;
    @(negedge clk);
    num_edges  = ne[3:0];
    done_trans = 1'b1;
    n = (ne > 6) ? 6 : ne;
    for (int d = 0; d < 3; d++) begin
      x.kind = 1; x.dut = d; x.tag = cyc + 1; x.lat = 2 + n + ((d == 1) ? 6 : 0);
      x.row = '0; x.bad = 1'b0; x.ovf = 1'b0; x.name = "latency";
      sb_q.push_back(x);
      if (drop) begin
        x.kind = 2; x.lat = 1; x.name = "done_pulse";
        sb_q.push_back(x);
      end
    end
    if (drop) begin
      tick(3);
      done_trans = 1'b0;
      tick(20);
    end else begin
      tick(20);
      done_trans = 1'b0;
      tick(3);
    end
  endtask

  task automatic load_t1();
    fm_mem[0] = row3(11488, 0, 0);
    fm_mem[1] = row3(6684, 0, 0);
    fm_mem[2] = row3(7687, 6093, 0);
    fm_mem[3] = row3(7687, 9853, 8976);
    fm_mem[4] = row3(0, 6684, 8976);
    fm_mem[5] = row3(0, 6093, 6093);
    fm_mem[6] = '0;
    fm_mem[7] = '0;
    src_mem[0] = 3'd1; dst_mem[0] = 3'd2;
    src_mem[1] = 3'd2; dst_mem[1] = 3'd3;
    src_mem[2] = 3'd3; dst_mem[2] = 3'd4;
    src_mem[3] = 3'd4; dst_mem[3] = 3'd5;
    src_mem[4] = 3'd4; dst_mem[4] = 3'd6;
    src_mem[5] = 3'd5; dst_mem[5] = 3'd6;
    src_mem[6] = 3'd0; dst_mem[6] = 3'd0;
    src_mem[7] = 3'd0; dst_mem[7] = 3'd0;
  endtask

  task automatic check_t1(input string tag);
    expect_row({tag, "_r0"}, 0, 0, row3(0, 0, 0), 1'b0, 1'b0);
    expect_row({tag, "_r1"}, 0, 1, row3(11488, 0, 0), 1'b0, 1'b0);
    expect_row({tag, "_r2"}, 0, 2, row3(6684, 0, 0), 1'b0, 1'b0);
    expect_row({tag, "_r3"}, 0, 3, row3(7687, 6093, 0), 1'b0, 1'b0);
    expect_row({tag, "_r4"}, 0, 4, row3(7687, 9853, 8976), 1'b0, 1'b0);
    expect_row({tag, "_r5"}, 0, 5, row3(7687, 16537, 17952), 1'b0, 1'b0);
    expect_row({tag, "_self_r0"}, 1, 0, row3(11488, 0, 0), 1'b0, 1'b0);
    expect_row({tag, "_self_r3"}, 1, 3, row3(15374, 15946, 8976), 1'b0, 1'b0);
    expect_row({tag, "_self_r5"}, 1, 5, row3(7687, 22630, 24045), 1'b0, 1'b0);
    expect_row({tag, "_wrap_r5"}, 2, 5, row3(7687, 16537, 17952), 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset      = 1'b0;
    done_trans = 1'b0;
    num_edges  = 4'd0;
    read_row   = 3'd0;
    load_t1();

    // Reset state; done_trans already high at reset exit must not start a run.
    tick(3);
    done_trans = 1'b1;
    chk("reset_coo_address", {61'd0, addr_v[0]}, 64'd0);
    chk("reset_done_comb", {61'd0, done_v}, 64'd0);
    tick(1);
    reset = 1'b1;
    tick(10);
    expect_row("reset_r0", 0, 0, row3(0, 0, 0), 1'b0, 1'b0);
    expect_row("reset_self_r5", 1, 5, row3(0, 0, 0), 1'b0, 1'b0);
    done_trans = 1'b0;
    tick(2);

    // T1 / T2: reference graph, plain and self-loop.
    run(6, 1'b0);
    check_t1("t1");

    // num_edges above the COO depth is clamped.
    run(15, 1'b0);
    expect_row("clamp_r5", 0, 5, row3(7687, 16537, 17952), 1'b0, 1'b0);

    // T3: repeated destination overflows; saturate vs wrap.
    fm_mem[0]  = row3(40000, 0, 0);
    src_mem[1] = 3'd1; dst_mem[1] = 3'd2;
    run(2, 1'b0);
    expect_row("t3_sat_r1", 0, 1, row3(65535, 0, 0), 1'b0, 1'b1);
    expect_row("t3_sat_r2", 0, 2, row3(0, 0, 0), 1'b0, 1'b1);
    expect_row("t3_wrap_r1", 2, 1, row3(14464, 0, 0), 1'b0, 1'b1);
    expect_row("t3_self_r0", 1, 0, row3(40000, 0, 0), 1'b0, 1'b1);
    expect_row("t3_self_r1", 1, 1, row3(65535, 0, 0), 1'b0, 1'b1);

    // T4: src id 0 and dst id 7 are skipped.
    load_t1();
    src_mem[0] = 3'd1; dst_mem[0] = 3'd2;
    src_mem[1] = 3'd0; dst_mem[1] = 3'd3;
    src_mem[2] = 3'd2; dst_mem[2] = 3'd7;
    src_mem[3] = 3'd3; dst_mem[3] = 3'd4;
    src_mem[4] = 3'd2; dst_mem[4] = 3'd2;
    run(5, 1'b0);
    expect_row("t4_r1", 0, 1, row3(18172, 0, 0), 1'b1, 1'b0);
    expect_row("t4_r2", 0, 2, row3(0, 0, 0), 1'b1, 1'b0);
    expect_row("t4_r3", 0, 3, row3(7687, 6093, 0), 1'b1, 1'b0);
    expect_row("t4_wrap_r1", 2, 1, row3(18172, 0, 0), 1'b1, 1'b0);

    // T4: zero edges.
    run(0, 1'b0);
    expect_row("t4_zero_r1", 0, 1, row3(0, 0, 0), 1'b0, 1'b0);
    expect_row("t4_zero_r5", 0, 5, row3(0, 0, 0), 1'b0, 1'b0);
    expect_row("t4_zero_self_r1", 1, 1, row3(6684, 0, 0), 1'b0, 1'b0);

    // T5: reset pulse during the third edge cycle.
    load_t1();
    @(negedge clk);
    read_row   = 3'd1;
    num_edges  = 4'd6;
    done_trans = 1'b1;
    tick(4);
    chk("t5_pre_coo_address", {61'd0, addr_v[0]}, 64'd2);
    reset = 1'b0;
    #1;
    chk("t5_coo_address", {61'd0, addr_v[0]}, 64'd0);
    chk("t5_read_fm_wm_row", {61'd0, fetch_v[0]}, 64'd0);
    chk("t5_adj_row", {16'd0, adj_v[0]}, 64'd0);
    #1;
    reset = 1'b1;
    tick(12);
    expect_row("t5_cleared_r1", 0, 1, row3(0, 0, 0), 1'b0, 1'b0);
    done_trans = 1'b0;
    tick(2);
    run(6, 1'b0);
    check_t1("t5");

    // T6: done_trans dropped mid-run; out-of-range read rows.
    run(6, 1'b1);
    expect_row("t6_r5", 0, 5, row3(7687, 16537, 17952), 1'b0, 1'b0);
    expect_row("t6_row6", 0, 6, row3(0, 0, 0), 1'b0, 1'b0);
    expect_row("t6_row7", 0, 7, row3(0, 0, 0), 1'b0, 1'b0);
    tick(3);

    // Anything still queued never arrived.
    foreach (sb_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s u%0d: expected event never observed", sb_q[i].name, sb_q[i].dut);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
